// File: rtl/vector_serializer_pkg.sv
// Shared constants for the vector serializer and its receive-side buffer.
package vector_serializer_pkg;

    // Default vector width shared by transmit and receive sides.
    localparam int VECTOR_WIDTH = 8;

    // Bit-order encodings for the MSB_FIRST parameter.
    localparam bit MSB_FIRST = 1'b1;
    localparam bit LSB_FIRST = 1'b0;

endpackage

// File: rtl/vector_serializer_shift.sv
// Shift register plus remaining-bit counter for the serializer.
// A load takes priority over a shift; the output end is chosen by MSB_FIRST.
module vector_serializer_shift
    import vector_serializer_pkg::*;
#(
    parameter int WIDTH     = VECTOR_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             output_bit,
    output logic             last,
    output logic             empty
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    remaining;

    // Load a fresh vector or advance one bit toward the output end.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            remaining <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            remaining <= CW'(WIDTH);
        end else if (shift) begin
            if (MSB_FIRST != LSB_FIRST) begin
                shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
                shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
            end
            remaining <= remaining - CW'(1);
        end
    end

    assign output_bit = (MSB_FIRST != LSB_FIRST) ? shift_reg[WIDTH-1] : shift_reg[0];
    assign last       = (remaining == CW'(1));
    assign empty      = (remaining == '0);

endmodule

// File: rtl/vector_serializer.sv
// Parallel-to-serial vector serializer with one holding register, so a
// second vector can wait while the first is shifted out with no bit gap.
// All outputs come straight from registers.
module vector_serializer
    import vector_serializer_pkg::*;
#(
    parameter int WIDTH     = VECTOR_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] vector,
    input  logic             vector_valid,
    output logic             vector_ready,
    output logic             output_bit,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last
);

    logic             busy;
    logic             hold_full;
    logic [WIDTH-1:0] hold;

    logic             accept;
    logic             fire;
    logic             last_fire;
    logic             shift_free;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             shift;
    logic             last;
    logic             empty;

    assign bit_valid    = busy;
    assign bit_last     = busy && last;
    assign vector_ready = !hold_full;

    assign accept     = vector_valid && vector_ready;
    assign fire       = bit_valid && bit_ready;
    assign last_fire  = fire && bit_last;
    assign shift_free = !busy || last_fire;

    // The held vector always goes first; otherwise a fresh accept loads
    // straight into the shifter so a last bit and a new vector meet with no bubble.
    assign load      = shift_free && (hold_full || accept);
    assign load_data = hold_full ? hold : vector;
    assign shift     = fire && !load && !empty;

    vector_serializer_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .shift      (shift),
        .output_bit (output_bit),
        .last       (last),
        .empty      (empty)
    );

    // Track shifter occupancy and manage the holding register.
    // NOTE: the hold register is reset too, so a vector discarded by reset can
    // never reappear; it is a single word, not a memory array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            hold_full <= 1'b0;
            hold      <= '0;
        end else if (shift_free) begin
            if (hold_full) begin
                busy <= 1'b1;
                if (accept) begin
                    hold <= vector;
                end else begin
                    hold_full <= 1'b0;
                end
            end else if (accept) begin
                busy <= 1'b1;
            end else begin
                busy <= 1'b0;
            end
        end else if (accept) begin
            hold      <= vector;
            hold_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
// Scoreboard bench for vector_serializer: one MSB-first and one LSB-first
// instance; expected bit streams are queued at issue time and popped by
// negedge monitors whenever a bit transfers.
module tb_vector_serializer;
    import vector_serializer_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_bit_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [W-1:0] vector;
    logic         vector_valid;
    logic         vector_ready;
    logic         output_bit;
    logic         bit_valid;
    logic         bit_ready;
    logic         bit_last;

    logic [W-1:0] l_vector;
    logic         l_vector_valid;
    logic         l_vector_ready;
    logic         l_output_bit;
    logic         l_bit_valid;
    logic         l_bit_ready;
    logic         l_bit_last;

    exp_bit_t q_msb[$];
    exp_bit_t q_lsb[$];

    int checks   = 0;
    int failures = 0;
    int waits;
    int n;

    always #5 clk = ~clk;

    vector_serializer #(.WIDTH(W), .MSB_FIRST(MSB_FIRST)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vector       (vector),
        .vector_valid (vector_valid),
        .vector_ready (vector_ready),
        .output_bit   (output_bit),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .bit_last     (bit_last)
    );

    vector_serializer #(.WIDTH(W), .MSB_FIRST(LSB_FIRST)) dut_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .vector       (l_vector),
        .vector_valid (l_vector_valid),
        .vector_ready (l_vector_ready),
        .output_bit   (l_output_bit),
        .bit_valid    (l_bit_valid),
        .bit_ready    (l_bit_ready),
        .bit_last     (l_bit_last)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // stream[W-1] is the first bit expected on the wire.
    task automatic push_stream(input logic [W-1:0] stream, input bit to_lsb);
        exp_bit_t e;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = stream[i];
            e.last = (i == 0);
            if (to_lsb) q_lsb.push_back(e);
            else        q_msb.push_back(e);
        end
    endtask

    // Offer v to the MSB-first instance until accepted; waits counts stalled cycles.
    task automatic send(input logic [W-1:0] v, input logic [W-1:0] stream, output int wait_cnt);
        wait_cnt     = 0;
        vector       = v;
        vector_valid = 1'b1;
        while (!vector_ready && wait_cnt < 50) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        if (wait_cnt >= 50) check("send_timeout", 32'(wait_cnt), 32'd0);
        push_stream(stream, 1'b0);
        @(posedge clk); #1;
        vector_valid = 1'b0;
        vector       = 8'hEE;
    endtask

    task automatic wait_idle(input string name);
        int cnt = 0;
        while ((q_msb.size() != 0 || q_lsb.size() != 0 || bit_valid || l_bit_valid) && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({name, "_drained"}, 32'(q_msb.size() + q_lsb.size()), 32'd0);
        check({name, "_idle_valid"}, 32'(bit_valid), 32'd0);
        check({name, "_idle_ready"}, 32'(vector_ready), 32'd1);
    endtask

    // MSB-first monitor: compare every transferred bit against the scoreboard.
    always @(negedge clk) begin
        exp_bit_t e;
        if (rst_n && bit_valid && bit_ready) begin
            if (q_msb.size() == 0) begin
                check("msb_unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = q_msb.pop_front();
                check("msb_bit", 32'(output_bit), 32'(e.b));
                check("msb_last", 32'(bit_last), 32'(e.last));
            end
        end
    end

    // LSB-first monitor.
    always @(negedge clk) begin
        exp_bit_t e;
        if (rst_n && l_bit_valid && l_bit_ready) begin
            if (q_lsb.size() == 0) begin
                check("lsb_unexpected_bit", 32'd1, 32'd0);
            end else begin
                e = q_lsb.pop_front();
                check("lsb_bit", 32'(l_output_bit), 32'(e.b));
                check("lsb_last", 32'(l_bit_last), 32'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        vector         = '0;
        vector_valid   = 1'b0;
        bit_ready      = 1'b1;
        l_vector       = '0;
        l_vector_valid = 1'b0;
        l_bit_ready    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_bit_last", 32'(bit_last), 32'd0);
        check("rst_output_bit", 32'(output_bit), 32'd0);
        check("rst_vector_ready", 32'(vector_ready), 32'd1);
        check("rst_lsb_bit_valid", 32'(l_bit_valid), 32'd0);
        check("rst_lsb_vector_ready", 32'(l_vector_ready), 32'd1);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic send: A5 -> 10100101, busy for exactly 8 cycles.
        check("basic_pre_idle", 32'(bit_valid), 32'd0);
        send(8'hA5, 8'hA5, waits);
        check("basic_valid_next", 32'(bit_valid), 32'd1);
        n = 0;
        while (bit_valid && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        check("basic_busy_cycles", 32'(n), 32'd8);
        wait_idle("basic");

        // Back-to-back: F0 then 0F, second waits in hold, 16 contiguous bits.
        send(8'hF0, 8'hF0, waits);
        send(8'h0F, 8'h0F, waits);
        check("b2b_hold_full_ready", 32'(vector_ready), 32'd0);
        n = 0;
        while (bit_valid && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("b2b_contiguous_cycles", 32'(n), 32'd15);
        wait_idle("b2b");

        // Backpressure: C3, stall 3 cycles after bit 2 (third bit 0 frozen).
        send(8'hC3, 8'hC3, waits);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_output_bit", 32'(output_bit), 32'd0);
            check("stall_bit_valid", 32'(bit_valid), 32'd1);
            check("stall_bit_last", 32'(bit_last), 32'd0);
            @(posedge clk); #1;
        end
        check("stall_end_output_bit", 32'(output_bit), 32'd0);
        bit_ready = 1'b1;
        wait_idle("stall");

        // Full and hold: 33 shifting, CC held, 55 waits until 33's last bit.
        send(8'h33, 8'h33, waits);
        send(8'hCC, 8'hCC, waits);
        check("full_ready_low", 32'(vector_ready), 32'd0);
        send(8'h55, 8'h55, waits);
        check("full_wait_cycles", 32'(waits), 32'd7);
        wait_idle("full");

        // LSB-first instance: 01 -> 10000000.
        check("lsb_ready", 32'(l_vector_ready), 32'd1);
        l_vector       = 8'h01;
        l_vector_valid = 1'b1;
        push_stream(8'b1000_0000, 1'b1);
        @(posedge clk); #1;
        l_vector_valid = 1'b0;
        l_vector       = 8'hFF;
        check("lsb_valid_next", 32'(l_bit_valid), 32'd1);
        wait_idle("lsb");

        // Async reset after bit 3 of FF, then 81 sends cleanly.
        send(8'hFF, 8'hFF, waits);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        q_msb.delete();
        #1;
        check("midrst_bit_valid", 32'(bit_valid), 32'd0);
        check("midrst_bit_last", 32'(bit_last), 32'd0);
        check("midrst_output_bit", 32'(output_bit), 32'd0);
        check("midrst_vector_ready", 32'(vector_ready), 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_idle", 32'(bit_valid), 32'd0);
        send(8'h81, 8'h81, waits);
        wait_idle("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
